// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two requesters share one BRAM write port and one read port.
// Each port has its own round-robin arbiter. A read that hits the address being
// written in the same cycle is held off one cycle. Read responses are tagged with
// the issuing requester and emitted READ_LATENCY cycles after acceptance.
module bram_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          wr_valid,
    output logic [1:0]          wr_ready,
    input  logic [2*ADDR_W-1:0] wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic [1:0]          rd_valid,
    output logic [1:0]          rd_ready,
    input  logic [2*ADDR_W-1:0] rd_addr,
    output logic [1:0]          rd_rsp_valid,
    output logic [DATA_W-1:0]   rd_rsp_data,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data
);

    localparam int LAST = READ_LATENCY - 1;

    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_req;
    logic [1:0]        rd_gnt;
    logic              wr_sel;
    logic              rd_sel;
    logic              hazard;
    logic [ADDR_W-1:0] wr_win_addr;
    logic [DATA_W-1:0] wr_win_data;
    logic [ADDR_W-1:0] rd_win_addr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [LAST:0]     pipe_vld;
    logic [LAST:0]     pipe_tag;

    // Round-robin pick: a lone requester wins, a tie goes to the pointer.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    // Arbitrate both ports; the read loses a same-address collision with the write.
    always_comb begin
        wr_gnt      = rst_n ? rr_pick(wr_valid, wr_ptr) : 2'b00;
        wr_sel      = wr_gnt[1];
        wr_win_addr = wr_sel ? wr_addr[ADDR_W +: ADDR_W] : wr_addr[0 +: ADDR_W];
        wr_win_data = wr_sel ? wr_data[DATA_W +: DATA_W] : wr_data[0 +: DATA_W];
        rd_req      = rst_n ? rr_pick(rd_valid, rd_ptr) : 2'b00;
        rd_sel      = rd_req[1];
        rd_win_addr = rd_sel ? rd_addr[ADDR_W +: ADDR_W] : rd_addr[0 +: ADDR_W];
        hazard      = (|wr_gnt) && (|rd_req) && (rd_win_addr == wr_win_addr);
        rd_gnt      = hazard ? 2'b00 : rd_req;
    end

    assign wr_ready     = wr_gnt;
    assign rd_ready     = rd_gnt;
    assign ram_wr_en    = |wr_gnt;
    assign ram_rd_en    = |rd_gnt;
    assign ram_wr_addr  = ram_wr_en ? wr_win_addr : wr_addr_q;
    assign ram_wr_data  = ram_wr_en ? wr_win_data : wr_data_q;
    assign ram_rd_addr  = ram_rd_en ? rd_win_addr : rd_addr_q;
    assign rd_rsp_data  = ram_rd_data;
    assign rd_rsp_valid = {pipe_vld[LAST] & pipe_tag[LAST], pipe_vld[LAST] & ~pipe_tag[LAST]};

    // After each grant the pointer favours the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (|wr_gnt) wr_ptr <= ~wr_sel;
            if (|rd_gnt) rd_ptr <= ~rd_sel;
        end
    end

    // Hold the last issued BRAM address/data while a port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            if (ram_wr_en) begin
                wr_addr_q <= wr_win_addr;
                wr_data_q <= wr_win_data;
            end
            if (ram_rd_en) rd_addr_q <= rd_win_addr;
        end
    end

    // Valid/tag shift register aligning each response with the BRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_vld[0] <= ram_rd_en;
            pipe_tag[0] <= rd_sel;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: one instance per legal read latency, each with
// its own BRAM model, driven by shared stimulus. A behavioural model checks every
// cycle; table vectors and hand sequences check the named corner cases.
module tb_bram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      wr_valid, rd_valid;
    logic [2*AW-1:0] wr_addr, rd_addr;
    logic [2*DW-1:0] wr_data;

    logic [1:0]    wr_ready, rd_ready, rsp_valid1;
    logic [DW-1:0] rsp_data1, ram_wr_data, ram_rd_data1;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;

    logic [1:0]    wr_ready2, rd_ready2, rsp_valid2;
    logic [DW-1:0] rsp_data2, ram_wr_data2, ram_rd_data2, rd_stage2;
    logic          ram_wr_en2, ram_rd_en2;
    logic [AW-1:0] ram_wr_addr2, ram_rd_addr2;

    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem2 [256];

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rsp_valid1), .rd_rsp_data(rsp_data1),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data1)
    );

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready2), .rd_addr(rd_addr),
        .rd_rsp_valid(rsp_valid2), .rd_rsp_data(rsp_data2),
        .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2),
        .ram_rd_en(ram_rd_en2), .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2)
    );

    // BRAM with unregistered output (latency 1).
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem1[i] <= i * 32'h01010101;
        end else begin
            if (ram_wr_en) mem1[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en) ram_rd_data1 <= mem1[ram_rd_addr];
        end
    end

    // BRAM with output register enabled (latency 2).
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem2[i] <= i * 32'h01010101;
        end else begin
            if (ram_wr_en2) mem2[ram_wr_addr2] <= ram_wr_data2;
            if (ram_rd_en2) rd_stage2 <= mem2[ram_rd_addr2];
            ram_rd_data2 <= rd_stage2;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          due;
        logic        tag;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q1[$];
    rsp_t        q2[$];
    int          cyc = 0;
    logic        m_wptr, m_rptr;
    logic [7:0]  m_last_wa, m_last_ra;
    logic [31:0] m_last_wd;
    logic [31:0] ref_mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [1:0] v, input logic p);
        if (v == 2'b00) return -1;
        if (v == 2'b11) return p ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        int          wi, ri;
        logic [7:0]  wa, ra;
        logic [31:0] wd;
        logic [1:0]  ewr, erd, ev;
        if (load) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = i * 32'h01010101;
        end
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            m_wptr    = 1'b0;
            m_rptr    = 1'b0;
            m_last_wa = '0;
            m_last_ra = '0;
            m_last_wd = '0;
        end else begin
            wi = pick(wr_valid, m_wptr);
            ri = pick(rd_valid, m_rptr);
            wa = (wi >= 0) ? wr_addr[wi*AW +: AW] : m_last_wa;
            wd = (wi >= 0) ? wr_data[wi*DW +: DW] : m_last_wd;
            ra = (ri >= 0) ? rd_addr[ri*AW +: AW] : m_last_ra;
            if (wi >= 0 && ri >= 0 && wa == ra) ri = -1;
            if (ri < 0) ra = m_last_ra;
            ewr = (wi < 0) ? 2'b00 : (wi == 1 ? 2'b10 : 2'b01);
            erd = (ri < 0) ? 2'b00 : (ri == 1 ? 2'b10 : 2'b01);
            chk("m_wr_ready", wr_ready, ewr);
            chk("m_rd_ready", rd_ready, erd);
            chk("m_rd_ready2", rd_ready2, erd);
            chk("m_ram_wr_en", ram_wr_en, wi >= 0);
            chk("m_ram_rd_en", ram_rd_en, ri >= 0);
            chk("m_ram_wr_addr", ram_wr_addr, wa);
            chk("m_ram_wr_data", ram_wr_data, wd);
            chk("m_ram_rd_addr", ram_rd_addr, ra);
            ev = 2'b00;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                ev = q1[0].tag ? 2'b10 : 2'b01;
                chk("m_rsp_data1", rsp_data1, q1[0].data);
                void'(q1.pop_front());
            end
            chk("m_rsp_valid1", rsp_valid1, ev);
            ev = 2'b00;
            if (q2.size() > 0 && q2[0].due == cyc) begin
                ev = q2[0].tag ? 2'b10 : 2'b01;
                chk("m_rsp_data2", rsp_data2, q2[0].data);
                void'(q2.pop_front());
            end
            chk("m_rsp_valid2", rsp_valid2, ev);
            if (ri >= 0) begin
                q1.push_back('{cyc + 1, ri == 1, ref_mem[ra]});
                q2.push_back('{cyc + 2, ri == 1, ref_mem[ra]});
                m_last_ra = ra;
                m_rptr    = (ri == 0);
            end
            if (wi >= 0) begin
                ref_mem[wa] = wd;
                m_last_wa   = wa;
                m_last_wd   = wd;
                m_wptr      = (wi == 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [1:0] wv, rv;
        logic [7:0] wa0, wa1, ra0, ra1;
        logic [1:0] ewr, erd;
        logic [7:0] ewa;
        logic       erd_en;
    } vec_t;

    vec_t tbl[5];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
    endtask

    initial begin
        logic [1:0]  gw, gr;
        logic [31:0] e;
        tbl[0] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 1'b0};
        tbl[1] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b00, 8'h20, 1'b0};
        tbl[2] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 1'b0};
        tbl[3] = '{2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b00, 8'h20, 1'b0};
        tbl[4] = '{2'b01, 2'b01, 8'h01, 8'h00, 8'h02, 8'h00, 2'b01, 2'b01, 8'h01, 1'b1};

        // Reset state, with requests already present.
        wr_valid = 2'b11; rd_valid = 2'b11;
        wr_addr = 16'h2010; rd_addr = 16'h2010; wr_data = 64'h1111_1111_2222_2222;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 2'b00);
        chk("rst_rd_ready", rd_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid1, 2'b00);
        chk("rst_ram_wr_en", ram_wr_en, 1'b0);
        chk("rst_ram_rd_en", ram_rd_en, 1'b0);
        chk("rst_ram_wr_addr", ram_wr_addr, 8'h00);
        chk("rst_ram_wr_data", ram_wr_data, 32'h0);
        chk("rst_ram_rd_addr", ram_rd_addr, 8'h00);
        idle();
        next_cycle();
        load = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // Table: write round-robin and concurrent write/read.
        for (int i = 0; i < 5; i++) begin
            wr_valid = tbl[i].wv;
            rd_valid = tbl[i].rv;
            wr_addr  = {tbl[i].wa1, tbl[i].wa0};
            rd_addr  = {tbl[i].ra1, tbl[i].ra0};
            wr_data  = {24'hC0DE00, tbl[i].wa1, 24'hC0DE00, tbl[i].wa0};
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].ewr);
            chk($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].erd);
            chk($sformatf("tbl%0d_ram_wr_addr", i), ram_wr_addr, tbl[i].ewa);
            chk($sformatf("tbl%0d_ram_rd_en", i), ram_rd_en, tbl[i].erd_en);
            next_cycle();
        end
        idle();

        // Read latency: write DEADBEEF to 0x05, requester 1 reads it back.
        wr_valid = 2'b01; wr_addr = 16'h0005; wr_data = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        chk("lat_wr_ready", wr_ready, 2'b01);
        next_cycle();
        idle();
        rd_valid = 2'b10; rd_addr = 16'h0500;
        @(negedge clk);
        chk("lat_rd_ready", rd_ready, 2'b10);
        next_cycle();
        idle();
        @(negedge clk);
        chk("lat1_rsp_valid", rsp_valid1, 2'b10);
        chk("lat1_rsp_data", rsp_data1, 32'hDEADBEEF);
        chk("lat2_rsp_early", rsp_valid2, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("lat2_rsp_valid", rsp_valid2, 2'b10);
        chk("lat2_rsp_data", rsp_data2, 32'hDEADBEEF);
        chk("lat1_rsp_once", rsp_valid1, 2'b00);
        next_cycle();

        // Same-address hazard: write 0x40 by req0, read 0x40 by req1.
        wr_valid = 2'b01; wr_addr = 16'h0040; wr_data = {32'h0, 32'h12345678};
        rd_valid = 2'b10; rd_addr = 16'h4000;
        @(negedge clk);
        chk("haz_rd_ready", rd_ready, 2'b00);
        chk("haz_wr_ready", wr_ready, 2'b01);
        chk("haz_ram_rd_en", ram_rd_en, 1'b0);
        next_cycle();
        wr_valid = 2'b00;
        @(negedge clk);
        chk("haz_retry_rd_ready", rd_ready, 2'b10);
        chk("haz_retry_addr", ram_rd_addr, 8'h40);
        next_cycle();
        idle();
        @(negedge clk);
        chk("haz_rsp1", {rsp_valid1, rsp_data1}, {2'b10, 32'h12345678});
        next_cycle();
        @(negedge clk);
        chk("haz_rsp2", {rsp_valid2, rsp_data2}, {2'b10, 32'h12345678});
        next_cycle();

        // Eight back-to-back reads, alternating requesters, preloaded data.
        for (int k = 0; k < 10; k++) begin
            rd_valid = (k >= 8) ? 2'b00 : ((k % 2) ? 2'b10 : 2'b01);
            rd_addr  = {2{8'(8'h80 + k)}};
            @(negedge clk);
            if (k < 8) chk($sformatf("pipe%0d_rd_ready", k), rd_ready, rd_valid);
            if (k >= 1 && k <= 8) begin
                e = 32'(8'h80 + k - 1) * 32'h01010101;
                chk($sformatf("pipe%0d_rsp1", k - 1), {rsp_valid1, rsp_data1},
                    {((k - 1) % 2) ? 2'b10 : 2'b01, e});
            end
            if (k >= 2) begin
                e = 32'(8'h80 + k - 2) * 32'h01010101;
                chk($sformatf("pipe%0d_rsp2", k - 2), {rsp_valid2, rsp_data2},
                    {((k - 2) % 2) ? 2'b10 : 2'b01, e});
            end
            next_cycle();
        end
        idle();

        // Reset with a read in flight: the response must be dropped.
        rd_valid = 2'b01; rd_addr = 16'h0033;
        @(negedge clk);
        chk("rstmid_rd_ready", rd_ready, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        chk("rstmid_rsp1_now", rsp_valid1, 2'b00);
        @(negedge clk);
        chk("rstmid_rsp1", rsp_valid1, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("rstmid_rsp2", rsp_valid2, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        wr_valid = 2'b11; wr_addr = 16'h6050; wr_data = 64'h6666_6666_5555_5555;
        @(negedge clk);
        chk("rstmid_wr_first", wr_ready, 2'b01);
        next_cycle();
        idle();
        next_cycle();

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!wr_valid[i] && $urandom_range(0, 2) != 0) begin
                    wr_valid[i] = 1'b1;
                    wr_addr[i*AW +: AW] = 8'(8'h60 + $urandom_range(0, 3));
                    wr_data[i*DW +: DW] = $urandom();
                end
                if (!rd_valid[i] && $urandom_range(0, 2) != 0) begin
                    rd_valid[i] = 1'b1;
                    rd_addr[i*AW +: AW] = 8'(8'h60 + $urandom_range(0, 3));
                end
            end
            @(negedge clk);
            gw = wr_ready;
            gr = rd_ready;
            next_cycle();
            wr_valid = wr_valid & ~gw;
            rd_valid = rd_valid & ~gr;
        end
        idle();
        repeat (4) next_cycle();
        @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
